// File: rtl/asyn_fifo_pkg.sv
// Shared async FIFO helpers: gray/binary conversion and default sizes.
package asyn_fifo_pkg;

    localparam int ADDR_SIZE_DEF   = 3;
    localparam int SYNC_STAGES_DEF = 2;

    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        logic [15:0] g;
        g[15] = b[15];
        for (int i = 0; i < 15; i++) begin
            g[i] = b[i] ^ b[i+1];
        end
        return g;
    endfunction

    // Each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [15:0] gray2bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop clock-domain synchronizer with asynchronous active-high reset.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer and empty flag of the async FIFO.
// Define RPTR_LEVEL_EN to add the rlevel / ralmost_empty outputs.
module rptr_empty
    import asyn_fifo_pkg::*;
#(
    parameter int ADDR_SIZE     = ADDR_SIZE_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rpop,
    input  logic [ADDR_SIZE:0]   wptr,
    output logic                 rempty,
    output logic                 ren,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr
`ifdef RPTR_LEVEL_EN
    ,
    output logic [ADDR_SIZE:0]   rlevel,
    output logic                 ralmost_empty
`endif
);

    localparam int PW = ADDR_SIZE + 1;

    logic [ADDR_SIZE:0] sync_wptr;
    logic [ADDR_SIZE:0] rbin;
    logic [ADDR_SIZE:0] rbin_next;
    logic [ADDR_SIZE:0] rgray_next;

    sync_ff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr),
        .q   (sync_wptr)
    );

    assign ren        = rpop & ~rempty;
    assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, ren};
    assign rgray_next = PW'(bin2gray(16'(rbin_next)));

    // Comparing the next pointer makes the last pop flag empty on its own edge.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbin_next;
            rptr   <= rgray_next;
            rempty <= (rgray_next == sync_wptr);
        end
    end

    assign raddr = rbin[ADDR_SIZE-1:0];

`ifdef RPTR_LEVEL_EN
    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] level_next;

    assign wbin       = PW'(gray2bin(16'(sync_wptr)));
    assign level_next = wbin - rbin_next;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
        end else begin
            rlevel        <= level_next;
            ralmost_empty <= (level_next <= PW'(AEMPTY_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: occupancy-count model plus directed literal checks.
module tb_rptr_empty;

    localparam int S = 2;

    logic       rclk;
    logic       rrst;
    logic       rpop;
    logic [3:0] wptr;
    logic       rempty;
    logic       ren;
    logic [2:0] raddr;
    logic [3:0] rptr;
`ifdef RPTR_LEVEL_EN
    logic [3:0] rlevel;
    logic       ralmost_empty;
`endif

    int total = 0;
    int bad   = 0;
    int wcnt  = 0;
    logic [3:0] wbin;

    rptr_empty dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rpop          (rpop),
        .wptr          (wptr),
        .rempty        (rempty),
        .ren           (ren),
        .raddr         (raddr),
        .rptr          (rptr)
`ifdef RPTR_LEVEL_EN
        ,
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty)
`endif
    );

    function automatic logic [3:0] gray(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
        end
    endtask

    initial begin
        rclk = 1'b0;
        #20;
        forever #5 rclk = ~rclk;
    end

    // Reader model: counts pops, sees the writer count SYNC_STAGES edges late.
    logic [3:0] mrbin;
    logic       mempty;
    logic [3:0] mlevel;
    logic       malm;
    logic [3:0] hist [S];
    logic       m_ren;
    logic [3:0] m_nb;
    logic [3:0] m_lvl;

    assign m_ren = rpop & ~mempty;
    assign m_nb  = mrbin + {3'b000, m_ren};
    assign m_lvl = hist[0] - m_nb;
    assign wbin  = wcnt[3:0];
    assign wptr  = gray(wbin);

    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            mrbin  <= '0;
            mempty <= 1'b1;
            mlevel <= '0;
            malm   <= 1'b1;
            for (int i = 0; i < S; i++) hist[i] <= '0;
        end else begin
            mrbin  <= m_nb;
            mempty <= (m_nb == hist[0]);
            mlevel <= m_lvl;
            malm   <= (m_lvl <= 4'd1);
            for (int i = 0; i < S - 1; i++) hist[i] <= hist[i+1];
            hist[S-1] <= wbin;
        end
    end

    always @(negedge rclk) begin
        chk("m_rempty", int'(rempty), int'(mempty));
        chk("m_ren", int'(ren), int'(rpop & ~mempty));
        chk("m_raddr", int'(raddr), int'(mrbin[2:0]));
        chk("m_rptr", int'(rptr), int'(gray(mrbin)));
`ifdef RPTR_LEVEL_EN
        chk("m_rlevel", int'(rlevel), int'(mlevel));
        chk("m_alm", int'(ralmost_empty), int'(malm));
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge rclk);
        #1;
        rrst = 1'b1;
        rpop = 1'b0;
        wcnt = 0;
        cyc(2);
        rrst = 1'b0;
    endtask

    logic [2:0] rec_addr [41];
    logic [3:0] rec_ptr  [41];
    int         npop;
    logic       ren_now;

    initial begin
        // Reset with no clock edge yet
        rrst = 1'b0;
        rpop = 1'b1;
        wcnt = 6'b000100;
        #1 rrst = 1'b1;
        #2;
        chk("rst_rempty", int'(rempty), 1);
        chk("rst_ren", int'(ren), 0);
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_rptr", int'(rptr), 0);
`ifdef RPTR_LEVEL_EN
        chk("rst_rlevel", int'(rlevel), 0);
        chk("rst_alm", int'(ralmost_empty), 1);
`endif
        #7;
        rpop = 1'b0;
        wcnt = 0;
        @(posedge rclk);
        #1 rrst = 1'b0;
        cyc(4);

        // Single entry: latency then one pop
        wcnt = 1;
        cyc(1);
        chk("lat_e1", int'(rempty), 1);
        cyc(1);
        chk("lat_e2", int'(rempty), 1);
        cyc(1);
        chk("lat_e3", int'(rempty), 0);
        rpop = 1'b1;
        #1;
        chk("pop1_ren", int'(ren), 1);
        cyc(1);
        rpop = 1'b0;
        chk("pop1_raddr", int'(raddr), 1);
        chk("pop1_rptr", int'(rptr), 4'b0001);
        chk("pop1_rempty", int'(rempty), 1);

        // Pop while empty is ignored
        rpop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("pope_ren", int'(ren), 0);
            cyc(1);
        end
        rpop = 1'b0;
        chk("pope_raddr", int'(raddr), 1);
        chk("pope_rptr", int'(rptr), 1);

        // Random traffic, occupancy kept within 8
        for (int i = 0; i < 3000; i++) begin
            rpop = ($urandom_range(0, 3) != 0);
            if (((wbin - mrbin) & 4'hF) < 8 && $urandom_range(0, 1) == 1)
                wcnt++;
            cyc(1);
        end

        // Wrap: 16 writes, continuous pops
        do_reset();
        cyc(3);
        npop = 0;
        for (int i = 0; i < 40; i++) begin
            if (wcnt < 16) wcnt++;
            rpop = 1'b1;
            #1 ren_now = ren;
            cyc(1);
            if (ren_now && npop < 40) begin
                npop++;
                rec_addr[npop] = raddr;
                rec_ptr[npop]  = rptr;
            end
        end
        rpop = 1'b0;
        chk("wrap_pops", npop, 16);
        if (npop >= 16) begin
            chk("wrap7_raddr", int'(rec_addr[7]), 7);
            chk("wrap7_rptr", int'(rec_ptr[7]), 4'b0100);
            chk("wrap8_raddr", int'(rec_addr[8]), 0);
            chk("wrap8_rptr", int'(rec_ptr[8]), 4'b1100);
            chk("wrap15_rptr", int'(rec_ptr[15]), 4'b1000);
            chk("wrap16_rptr", int'(rec_ptr[16]), 0);
            chk("wrap16_raddr", int'(rec_addr[16]), 0);
        end

        // Drain a full FIFO
        do_reset();
        wcnt = 8;
        cyc(4);
        chk("drain_rempty0", int'(rempty), 0);
`ifdef RPTR_LEVEL_EN
        chk("drain_lvl8", int'(rlevel), 8);
        chk("drain_alm8", int'(ralmost_empty), 0);
`endif
        rpop = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk("drain_rempty", int'(rempty), (i == 8) ? 1 : 0);
`ifdef RPTR_LEVEL_EN
            chk("drain_lvl", int'(rlevel), 8 - i);
            chk("drain_alm", int'(ralmost_empty), (8 - i <= 1) ? 1 : 0);
`endif
        end
        rpop = 1'b0;

        // Async reset mid-drain
        do_reset();
        wcnt = 8;
        cyc(4);
        rpop = 1'b1;
        cyc(3);
`ifdef RPTR_LEVEL_EN
        chk("mid_lvl5", int'(rlevel), 5);
`endif
        @(negedge rclk);
        #2 rrst = 1'b1;
        #1;
        chk("mid_rempty", int'(rempty), 1);
        chk("mid_ren", int'(ren), 0);
        chk("mid_raddr", int'(raddr), 0);
        chk("mid_rptr", int'(rptr), 0);
`ifdef RPTR_LEVEL_EN
        chk("mid_lvl", int'(rlevel), 0);
        chk("mid_alm", int'(ralmost_empty), 1);
`endif
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        rpop = 1'b0;
        cyc(1);
        chk("resync_e1", int'(rempty), 1);
        cyc(1);
        chk("resync_e2", int'(rempty), 1);
        cyc(1);
        chk("resync_e3", int'(rempty), 0);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
